// File: rtl/alu181_pkg.sv
// alu181_pkg
// Shared types and constants for the nibble-serial 74181 slice sequencer.
//   alu_state_t : sequencer FSM state encoding
//   SLICE_W     : data width of one 74181 slice
//   S_* / M_*   : select/mode pairs for the common operations
package alu181_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    localparam logic [3:0] S_ADD      = 4'b1001;
    localparam logic       M_ADD      = 1'b0;
    localparam logic [3:0] S_XOR      = 4'b0110;
    localparam logic       M_XOR      = 1'b1;
    localparam logic [3:0] S_AMINUSB  = 4'b0110;
    localparam logic       M_AMINUSB  = 1'b0;

endpackage

// File: rtl/alu181_slice_sequencer.sv
// alu181_slice_sequencer
// Time-shares one external 4-bit 74181 slice to execute a W = 4*NIBBLES bit
// operation, one nibble per cycle, LSB first, with the slice carry-out
// registered and fed back as the next nibble's carry-in.
//
// Ports:
//   clk, rst_n, ena          clock, synchronous active-low reset, clock enable
//   cmd_valid/cmd_ready      command handshake (cmd_a, cmd_b, cmd_s, cmd_m, cmd_cn)
//   alu_a/b/s/m/cn           drive to the external slice (zero outside RUN)
//   alu_f/alu_cn4/alu_eq     slice results, combinational from alu_*
//   rsp_valid/rsp_ready      response handshake (rsp_f, rsp_cout, rsp_eq, rsp_zero)
//   busy                     high in RUN and DONE
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | driving nibble idx to the slice, capturing its result and carry
// DONE  | holding the assembled response until rsp_ready
module alu181_slice_sequencer
    import alu181_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,

    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [SLICE_W*NIBBLES-1:0]   cmd_a,
    input  logic [SLICE_W*NIBBLES-1:0]   cmd_b,
    input  logic [3:0]                   cmd_s,
    input  logic                         cmd_m,
    input  logic                         cmd_cn,

    output logic [3:0]                   alu_a,
    output logic [3:0]                   alu_b,
    output logic [3:0]                   alu_s,
    output logic                         alu_m,
    output logic                         alu_cn,
    input  logic [3:0]                   alu_f,
    input  logic                         alu_cn4,
    input  logic                         alu_eq,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [SLICE_W*NIBBLES-1:0]   rsp_f,
    output logic                         rsp_cout,
    output logic                         rsp_eq,
    output logic                         rsp_zero,

    output logic                         busy
);

    localparam int W     = SLICE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    alu_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic [3:0]       s_q,     s_d;
    logic             m_q,     m_d;
    logic             carry_q, carry_d;
    logic             eq_q,    eq_d;
    logic [W-1:0]     f_q,     f_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        m_d       = m_q;
        carry_d   = carry_q;
        eq_d      = eq_q;
        f_d       = f_q;

        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = 4'd0;
        alu_b     = 4'd0;
        alu_s     = 4'd0;
        alu_m     = 1'b0;
        alu_cn    = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    s_d     = cmd_s;
                    m_d     = cmd_m;
                    carry_d = cmd_cn;
                    idx_d   = '0;
                    eq_d    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                alu_a   = a_q[SLICE_W*idx_q +: SLICE_W];
                alu_b   = b_q[SLICE_W*idx_q +: SLICE_W];
                alu_s   = s_q;
                alu_m   = m_q;
                alu_cn  = carry_q;
                f_d[SLICE_W*idx_q +: SLICE_W] = alu_f;
                // Carry stays in raw 74181 polarity; it is never inverted here.
                carry_d = alu_cn4;
                eq_d    = eq_q & alu_eq;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshakes qualify on ena implicitly: nothing commits unless ena is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= 4'd0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            f_q     <= '0;
        end else if (ena) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
            f_q     <= f_d;
        end
    end

    assign rsp_f    = f_q;
    assign rsp_cout = carry_q;
    assign rsp_eq   = eq_q;
    assign rsp_zero = ~|f_q;
    assign busy     = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_alu181_slice_sequencer.sv
// tb_alu181_slice_sequencer
// Two sequencer instances (NIBBLES = 2 and 4), each wired to a behavioural
// 74181 slice. Responses are checked against a scoreboard queue filled when
// each command is issued.
module tb_alu181_slice_sequencer;
    import alu181_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic ena;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Active-high 74181 function table; A=B output modelled as nibble equality.
    // Returns {eq, cn4, f}.
    function automatic logic [5:0] slice_model(input logic [3:0] a, input logic [3:0] b,
                                               input logic [3:0] s, input logic m,
                                               input logic cn);
        logic [3:0] x, y, f;
        logic [4:0] sum;
        x = 4'd0;
        y = 4'd0;
        case (s)
            4'd0:  begin x = a;          y = 4'h0;   end
            4'd1:  begin x = a | b;      y = 4'h0;   end
            4'd2:  begin x = a | ~b;     y = 4'h0;   end
            4'd3:  begin x = 4'h0;       y = 4'hF;   end
            4'd4:  begin x = a;          y = a & ~b; end
            4'd5:  begin x = a | b;      y = a & ~b; end
            4'd6:  begin x = a;          y = ~b;     end
            4'd7:  begin x = a & ~b;     y = 4'hF;   end
            4'd8:  begin x = a;          y = a & b;  end
            4'd9:  begin x = a;          y = b;      end
            4'd10: begin x = a | ~b;     y = a & b;  end
            4'd11: begin x = a & b;      y = 4'hF;   end
            4'd12: begin x = a;          y = a;      end
            4'd13: begin x = a | b;      y = a;      end
            4'd14: begin x = a | ~b;     y = a;      end
            default: begin x = a;        y = 4'hF;   end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {4'd0, ~cn};
        if (m) begin
            case (s)
                4'd0:  f = ~a;
                4'd1:  f = ~(a | b);
                4'd2:  f = ~a & b;
                4'd3:  f = 4'h0;
                4'd4:  f = ~(a & b);
                4'd5:  f = ~b;
                4'd6:  f = a ^ b;
                4'd7:  f = a & ~b;
                4'd8:  f = ~a | b;
                4'd9:  f = ~(a ^ b);
                4'd10: f = b;
                4'd11: f = a & b;
                4'd12: f = 4'hF;
                4'd13: f = a | ~b;
                4'd14: f = a | b;
                default: f = a;
            endcase
        end else begin
            f = sum[3:0];
        end
        return {a == b, ~sum[4], f};
    endfunction

    // NIBBLES = 2 instance
    logic       d2_cmd_valid, d2_cmd_ready, d2_cmd_m, d2_cmd_cn;
    logic [7:0] d2_cmd_a, d2_cmd_b;
    logic [3:0] d2_cmd_s;
    logic [3:0] d2_alu_a, d2_alu_b, d2_alu_s, d2_alu_f;
    logic       d2_alu_m, d2_alu_cn, d2_alu_cn4, d2_alu_eq;
    logic       d2_rsp_valid, d2_rsp_ready, d2_rsp_cout, d2_rsp_eq, d2_rsp_zero, d2_busy;
    logic [7:0] d2_rsp_f;

    assign {d2_alu_eq, d2_alu_cn4, d2_alu_f} =
        slice_model(d2_alu_a, d2_alu_b, d2_alu_s, d2_alu_m, d2_alu_cn);

    alu181_slice_sequencer #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready),
        .cmd_a(d2_cmd_a), .cmd_b(d2_cmd_b), .cmd_s(d2_cmd_s), .cmd_m(d2_cmd_m), .cmd_cn(d2_cmd_cn),
        .alu_a(d2_alu_a), .alu_b(d2_alu_b), .alu_s(d2_alu_s), .alu_m(d2_alu_m), .alu_cn(d2_alu_cn),
        .alu_f(d2_alu_f), .alu_cn4(d2_alu_cn4), .alu_eq(d2_alu_eq),
        .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready),
        .rsp_f(d2_rsp_f), .rsp_cout(d2_rsp_cout), .rsp_eq(d2_rsp_eq), .rsp_zero(d2_rsp_zero),
        .busy(d2_busy)
    );

    // NIBBLES = 4 instance
    logic        d4_cmd_valid, d4_cmd_ready, d4_cmd_m, d4_cmd_cn;
    logic [15:0] d4_cmd_a, d4_cmd_b;
    logic [3:0]  d4_cmd_s;
    logic [3:0]  d4_alu_a, d4_alu_b, d4_alu_s, d4_alu_f;
    logic        d4_alu_m, d4_alu_cn, d4_alu_cn4, d4_alu_eq;
    logic        d4_rsp_valid, d4_rsp_ready, d4_rsp_cout, d4_rsp_eq, d4_rsp_zero, d4_busy;
    logic [15:0] d4_rsp_f;

    assign {d4_alu_eq, d4_alu_cn4, d4_alu_f} =
        slice_model(d4_alu_a, d4_alu_b, d4_alu_s, d4_alu_m, d4_alu_cn);

    alu181_slice_sequencer #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(d4_cmd_valid), .cmd_ready(d4_cmd_ready),
        .cmd_a(d4_cmd_a), .cmd_b(d4_cmd_b), .cmd_s(d4_cmd_s), .cmd_m(d4_cmd_m), .cmd_cn(d4_cmd_cn),
        .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_s(d4_alu_s), .alu_m(d4_alu_m), .alu_cn(d4_alu_cn),
        .alu_f(d4_alu_f), .alu_cn4(d4_alu_cn4), .alu_eq(d4_alu_eq),
        .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready),
        .rsp_f(d4_rsp_f), .rsp_cout(d4_rsp_cout), .rsp_eq(d4_rsp_eq), .rsp_zero(d4_rsp_zero),
        .busy(d4_busy)
    );

    typedef struct {
        logic [15:0] f;
        logic        cout;
        logic        eq;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] s;
        logic       m;
        logic       cn;
        logic [7:0] f;
        logic       cout;
        logic       eq;
        logic       zero;
    } vec_t;

    exp_t q2[$];
    exp_t q4[$];
    exp_t e2, e4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n && ena && d2_rsp_valid && d2_rsp_ready) begin
            if (q2.size() == 0) begin
                timeout("d2_unexpected_response");
            end else begin
                e2 = q2.pop_front();
                check("d2_rsp_f",    32'(d2_rsp_f),    32'(e2.f[7:0]));
                check("d2_rsp_cout", 32'(d2_rsp_cout), 32'(e2.cout));
                check("d2_rsp_eq",   32'(d2_rsp_eq),   32'(e2.eq));
                check("d2_rsp_zero", 32'(d2_rsp_zero), 32'(e2.zero));
            end
        end
        if (rst_n && ena && d4_rsp_valid && d4_rsp_ready) begin
            if (q4.size() == 0) begin
                timeout("d4_unexpected_response");
            end else begin
                e4 = q4.pop_front();
                check("d4_rsp_f",    32'(d4_rsp_f),    32'(e4.f));
                check("d4_rsp_cout", 32'(d4_rsp_cout), 32'(e4.cout));
                check("d4_rsp_eq",   32'(d4_rsp_eq),   32'(e4.eq));
                check("d4_rsp_zero", 32'(d4_rsp_zero), 32'(e4.zero));
            end
        end
    end

    // Present a command to dut2 and return #1 after the accepting edge.
    task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                         input logic m, input logic cn);
        int t;
        d2_cmd_a = a; d2_cmd_b = b; d2_cmd_s = s; d2_cmd_m = m; d2_cmd_cn = cn;
        d2_cmd_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!(d2_cmd_ready && ena) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout("d2_cmd_accept");
        @(posedge clk);
        #1;
        d2_cmd_valid = 1'b0;
    endtask

    task automatic drain2();
        int t;
        t = 0;
        while (q2.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) timeout("d2_drain");
    endtask

    task automatic wait_valid2();
        int t;
        t = 0;
        while (!d2_rsp_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 20) timeout("d2_rsp_valid");
    endtask

    vec_t vecs[7];
    int   t_acc;
    int   acc[6];

    initial begin
        vecs[0] = '{8'hFF, 8'h01, S_ADD,     M_ADD,     1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h5A, 8'h5A, S_XOR,     M_XOR,     1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'h5A, 8'h5B, S_XOR,     M_XOR,     1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h50, 8'h23, S_AMINUSB, M_AMINUSB, 1'b0, 8'h2D, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h77, 8'h77, S_AMINUSB, M_AMINUSB, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h12, 8'h34, S_ADD,     M_ADD,     1'b0, 8'h47, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hF0, 8'h3C, 4'b1011,   1'b1,      1'b1, 8'h30, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        ena   = 1'b1;
        d2_cmd_valid = 1'b0; d2_cmd_a = 8'h00; d2_cmd_b = 8'h00; d2_cmd_s = 4'h0;
        d2_cmd_m = 1'b0; d2_cmd_cn = 1'b0; d2_rsp_ready = 1'b1;
        d4_cmd_valid = 1'b0; d4_cmd_a = 16'h0; d4_cmd_b = 16'h0; d4_cmd_s = 4'h0;
        d4_cmd_m = 1'b0; d4_cmd_cn = 1'b0; d4_rsp_ready = 1'b1;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 32'({d2_cmd_ready, d2_rsp_valid, d2_busy}), 32'(3'b100));
        check("reset_alu",  32'({d2_alu_a, d2_alu_b, d2_alu_s, d2_alu_m, d2_alu_cn}), 32'(0));
        check("reset_rsp",  32'({d2_rsp_f, d2_rsp_cout, d2_rsp_eq}), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with carry ripple across the nibble boundary, with slice-drive timing
        q2.push_back('{16'h0040, 1'b1, 1'b0, 1'b0});
        send2(8'h3F, 8'h01, S_ADD, M_ADD, 1'b1);
        t_acc = cyc;
        check("run0_alu_cn",  32'(d2_alu_cn), 32'(1));
        check("run0_alu_ab",  32'({d2_alu_a, d2_alu_b}), 32'(8'hF1));
        check("run0_alu_sm",  32'({d2_alu_s, d2_alu_m}), 32'({S_ADD, M_ADD}));
        check("run0_busy",    32'({d2_busy, d2_cmd_ready, d2_rsp_valid}), 32'(3'b100));
        @(posedge clk);
        #1;
        check("run1_alu_cn",  32'(d2_alu_cn), 32'(0));
        check("run1_alu_ab",  32'({d2_alu_a, d2_alu_b}), 32'(8'h30));
        check("run1_no_rsp",  32'(d2_rsp_valid), 32'(0));
        wait_valid2();
        // Edges counted from and including the accepting edge.
        check("latency_edges", 32'(cyc - t_acc + 1), 32'(3));
        check("done_alu_idle", 32'({d2_alu_a, d2_alu_b, d2_alu_s, d2_alu_m, d2_alu_cn}), 32'(0));
        drain2();

        // Table of single operations
        for (int i = 0; i < 7; i++) begin
            q2.push_back('{{8'h00, vecs[i].f}, vecs[i].cout, vecs[i].eq, vecs[i].zero});
            send2(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cn);
            drain2();
        end

        // Response backpressure with a competing command held on the input
        d2_rsp_ready = 1'b0;
        q2.push_back('{16'h0040, 1'b1, 1'b0, 1'b0});
        send2(8'h3F, 8'h01, S_ADD, M_ADD, 1'b1);
        wait_valid2();
        d2_cmd_a = 8'hAA; d2_cmd_b = 8'h55; d2_cmd_s = S_ADD; d2_cmd_m = M_ADD; d2_cmd_cn = 1'b1;
        d2_cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold", 32'({d2_rsp_valid, d2_cmd_ready, d2_busy, d2_rsp_f,
                                  d2_rsp_cout, d2_rsp_eq, d2_rsp_zero}),
                  32'({1'b1, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0}));
        end
        d2_cmd_valid = 1'b0;
        d2_rsp_ready = 1'b1;
        drain2();
        check("bp_back_idle", 32'({d2_cmd_ready, d2_busy, d2_rsp_valid}), 32'(3'b100));

        // Clock-enable stall in the first RUN cycle
        q2.push_back('{16'h0040, 1'b1, 1'b0, 1'b0});
        send2(8'h3F, 8'h01, S_ADD, M_ADD, 1'b1);
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("stall_frozen", 32'({d2_alu_a, d2_alu_b, d2_alu_cn, d2_busy, d2_rsp_valid}),
                  32'({4'hF, 4'h1, 1'b1, 1'b1, 1'b0}));
        end
        ena = 1'b1;
        @(posedge clk);
        #1;
        check("stall_resume", 32'({d2_alu_a, d2_alu_b, d2_alu_cn}), 32'({4'h3, 4'h0, 1'b0}));
        drain2();

        // Reset in the middle of RUN aborts without a response
        send2(8'h12, 8'h34, S_ADD, M_ADD, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrun_rst_ctrl", 32'({d2_cmd_ready, d2_rsp_valid, d2_busy}), 32'(3'b100));
        check("midrun_rst_alu",  32'({d2_alu_a, d2_alu_b, d2_alu_s, d2_alu_m, d2_alu_cn}), 32'(0));
        repeat (5) @(posedge clk);
        #1;
        check("midrun_rst_no_rsp", 32'({d2_rsp_valid, d2_busy}), 32'(0));

        // Back-to-back ADDs on the 4-nibble instance
        d4_rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [15:0] a, b;
            logic        cn;
            logic [16:0] sum;
            int          t;
            a  = 16'($urandom);
            b  = 16'($urandom);
            cn = 1'($urandom_range(0, 1));
            if (k == 2) b = a;
            if (k == 3) begin a = 16'hFFFF; b = 16'h0001; cn = 1'b1; end
            sum = {1'b0, a} + {1'b0, b} + {16'd0, ~cn};
            q4.push_back('{sum[15:0], ~sum[16], a == b, sum[15:0] == 16'h0});
            d4_cmd_a = a; d4_cmd_b = b; d4_cmd_s = S_ADD; d4_cmd_m = M_ADD; d4_cmd_cn = cn;
            d4_cmd_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!d4_cmd_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) timeout("d4_cmd_accept");
            acc[k] = cyc;
            if (k > 0) check("b2b_spacing", 32'(acc[k] - acc[k-1]), 32'(6));
            @(posedge clk);
            #1;
        end
        d4_cmd_valid = 1'b0;
        begin
            int t;
            t = 0;
            while (q4.size() != 0 && t < 100) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (t >= 100) timeout("d4_drain");
        end
        check("d4_final_idle", 32'({d4_cmd_ready, d4_busy, d4_rsp_valid}), 32'(3'b100));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
